hazard_ctrl_n: RTL and testbench
================================

Name: hazard_ctrl_n

Overview:
Parametrised hazard/forwarding controller for the deeper in-order integer pipeline.
- Generalises forwarding to N_FWD downstream stages and load-use stalls to any stage whose result is not yet available.
- Adds a sequential scoreboard and FSM for one multi-cycle mul/div unit, plus branch flush of a configurable-depth fetch pipe.
- Sits beside the datapath. Drives the execute operand-mux selects and the stall/flush controls for every stage.

Parameters:
N_FWD, 3, number of forwarding source stages after execute; index 0 is youngest (MEM1), N_FWD-1 is writeback
FETCH_STG, 2, number of fetch stages flushed on redirect
REG_AW, 5, register address width
SELW, $clog2(N_FWD+1), forward select width

Ports:
clk  in  1  clock
rstN  in  1  asynchronous active-low reset
r1AddrD  in  REG_AW  decode source 1
r2AddrD  in  REG_AW  decode source 2
r1AddrE  in  REG_AW  execute source 1
r2AddrE  in  REG_AW  execute source 2
rdE  in  REG_AW  execute destination
regWriteE  in  1  execute writes rd
notReadyE  in  1  execute result not available next cycle (load)
rdStg  in  N_FWD*REG_AW  destination per stage, stage i at bits [i*REG_AW +: REG_AW]
regWriteStg  in  N_FWD  write enable per stage
notReadyStg  in  N_FWD  stage i result not yet forwardable
mdStartE  in  1  mul/div issued from execute this cycle
mdRdE  in  REG_AW  mul/div destination
mdDone  in  1  mul/div result written this cycle
wrongBranchE  in  1  execute redirect
fwdAE  out  SELW  0 = regfile, i+1 = stage i
fwdBE  out  SELW  as fwdAE
stallF  out  1  hold fetch
stallD  out  1  hold decode
flushD  out  1  bubble decode
flushE  out  1  bubble execute
flushF  out  FETCH_STG  per-fetch-stage flush
mdBusy  out  1  mul/div scoreboard occupied

Behaviour:
- Clock/reset: single clock `clk`. Reset `rstN` is asynchronous and active-low.
- Forwarding (combinational): a match requires rdStg[i]==rEAddr, rdStg[i]!=0 and regWriteStg[i].
  - The lowest matching index wins. fwd = i+1; no match -> 0.
  - A winning match with notReadyStg[i]=1 still selects i+1 and raises stallE-hazard (below).
- Load-use stall: useStall is raised by either condition:
  - regWriteE & notReadyE & rdE!=0 & (r1AddrD==rdE | r2AddrD==rdE).
  - A winning forwarding match in execute with notReadyStg set.
- Mul/div FSM, states IDLE, BUSY, WB (registered state, mdRdQ register):
  - IDLE: on mdStartE, latch mdRdQ=mdRdE and go to BUSY.
  - BUSY: on mdDone go to WB. mdStartE in BUSY is illegal; decode is stalled so it cannot occur.
  - WB: one cycle, then IDLE. mdStartE in WB is accepted and goes to BUSY with a new mdRdQ.
  - mdBusy = (state==BUSY).
  - mdStall = mdBusy & mdRdQ!=0 & (r1AddrD==mdRdQ | r2AddrD==mdRdQ | decode is a mul/div).
  - Decode mul/div is signalled by the caller gating mdStartE one cycle later. For this block, mdStall is raised on any source match only.
- Outputs:
  - stallF = stallD = useStall | mdStall.
  - flushE = useStall | mdStall | wrongBranchE.
  - flushD = wrongBranchE.
  - flushF = {FETCH_STG{wrongBranchE}}.
- Priority: wrongBranchE with a simultaneous stall gives flushD=1 and stallD=1. Flush has precedence in the stage register.
- mdStartE in the same cycle as wrongBranchE: ignored. The FSM stays IDLE because the instruction is squashed.
- Reset mid-operation: state=IDLE and mdRdQ=0 immediately. All outputs are combinational from state/inputs, so they go to 0 once the inputs are 0.
- Register x0 is never a hazard.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs stallCnt[31:0] and flushCnt[31:0].
  - Counters increment on cycles with stallD=1 and flushE=1 respectively.
  - They saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- N_FWD=3, rdStg={7,7,7}, all regWrite=1, r1AddrE=7 -> fwdAE=1 (stage 0 wins). Clear stage 0 -> fwdAE=2.
- regWriteE=1, notReadyE=1, rdE=5, r2AddrD=5 -> stallF=stallD=flushE=1 for one cycle. rdE=0 -> no stall.
- mdStartE, mdRdE=9; r1AddrD=9 for 6 cycles, mdDone at cycle 5 -> mdBusy and stallD high cycles 1-5, low in WB.
- wrongBranchE=1 with useStall=1 -> flushD=1, flushE=1, flushF=2'b11. mdStartE is ignored (FSM stays IDLE).
- Assert rstN=0 mid-BUSY asynchronously -> mdBusy=0 before the next clk edge. After release, no stall on r1AddrD=9.
- HAZARD_PERF_EN: 4 stall cycles plus 1 branch -> stallCnt=4, flushCnt=5.

Source files
------------

// File: rtl/hazard_ctrl_n_if.sv
// rtl/hazard_ctrl_n_if.sv - hazard controller signal bundle (HAZARD_PERF_EN adds perf counters)
interface hazard_ctrl_n_if #(
    parameter int N_FWD     = 3,
    parameter int FETCH_STG = 2,
    parameter int REG_AW    = 5,
    parameter int SELW      = $clog2(N_FWD + 1)
);
    // Decode / execute operand and destination addresses
    logic [REG_AW-1:0]       r1AddrD;
    logic [REG_AW-1:0]       r2AddrD;
    logic [REG_AW-1:0]       r1AddrE;
    logic [REG_AW-1:0]       r2AddrE;
    logic [REG_AW-1:0]       rdE;
    logic                    regWriteE;
    logic                    notReadyE;
    // Downstream forwarding sources, stage 0 youngest
    logic [N_FWD*REG_AW-1:0] rdStg;
    logic [N_FWD-1:0]        regWriteStg;
    logic [N_FWD-1:0]        notReadyStg;
    // Multi-cycle mul/div unit
    logic                    mdStartE;
    logic [REG_AW-1:0]       mdRdE;
    logic                    mdDone;
    logic                    wrongBranchE;
    // Controls back to the datapath
    logic [SELW-1:0]         fwdAE;
    logic [SELW-1:0]         fwdBE;
    logic                    stallF;
    logic                    stallD;
    logic                    flushD;
    logic                    flushE;
    logic [FETCH_STG-1:0]    flushF;
    logic                    mdBusy;
`ifdef HAZARD_PERF_EN
    logic [31:0]             stallCnt;
    logic [31:0]             flushCnt;
`endif

    // Datapath side
    modport master (
        output r1AddrD, r2AddrD, r1AddrE, r2AddrE, rdE, regWriteE, notReadyE,
        output rdStg, regWriteStg, notReadyStg,
        output mdStartE, mdRdE, mdDone, wrongBranchE,
        input  fwdAE, fwdBE, stallF, stallD, flushD, flushE, flushF, mdBusy
`ifdef HAZARD_PERF_EN
        , input stallCnt, flushCnt
`endif
    );

    // Hazard controller side
    modport slave (
        input  r1AddrD, r2AddrD, r1AddrE, r2AddrE, rdE, regWriteE, notReadyE,
        input  rdStg, regWriteStg, notReadyStg,
        input  mdStartE, mdRdE, mdDone, wrongBranchE,
        output fwdAE, fwdBE, stallF, stallD, flushD, flushE, flushF, mdBusy
`ifdef HAZARD_PERF_EN
        , output stallCnt, flushCnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl_n.sv
// rtl/hazard_ctrl_n.sv - N-stage forwarding, load-use/mul-div stalls and branch flush (HAZARD_PERF_EN adds stall/flush counters)
module hazard_ctrl_n #(
    parameter int N_FWD     = 3,
    parameter int FETCH_STG = 2,
    parameter int REG_AW    = 5,
    parameter int SELW      = $clog2(N_FWD + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    hazard_ctrl_n_if.slave   hz
);

    typedef enum logic [1:0] {IDLE, BUSY, WB} mdStateT;

    mdStateT           mdState;
    mdStateT           mdStateNext;
    logic [REG_AW-1:0] mdRdQ;
    logic [REG_AW-1:0] mdRdNext;

    logic [SELW-1:0]   fwdA;
    logic [SELW-1:0]   fwdB;
    logic              notReadyA;
    logic              notReadyB;
    logic              loadUse;
    logic              useStall;
    logic              mdStall;
    logic              mdBusyInt;
    logic              stallAny;

    // Forward select: scan oldest to youngest so the youngest match overwrites
    always_comb begin
        fwdA      = '0;
        fwdB      = '0;
        notReadyA = 1'b0;
        notReadyB = 1'b0;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (hz.regWriteStg[i] && (hz.rdStg[i*REG_AW +: REG_AW] != '0)
                    && (hz.rdStg[i*REG_AW +: REG_AW] == hz.r1AddrE)) begin
                fwdA      = SELW'(i + 1);
                notReadyA = hz.notReadyStg[i];
            end
            if (hz.regWriteStg[i] && (hz.rdStg[i*REG_AW +: REG_AW] != '0)
                    && (hz.rdStg[i*REG_AW +: REG_AW] == hz.r2AddrE)) begin
                fwdB      = SELW'(i + 1);
                notReadyB = hz.notReadyStg[i];
            end
        end
    end

    // Load in execute feeding decode, or execute needing a value still in flight
    always_comb begin
        loadUse  = hz.regWriteE && hz.notReadyE && (hz.rdE != '0)
                   && ((hz.r1AddrD == hz.rdE) || (hz.r2AddrD == hz.rdE));
        useStall = loadUse || notReadyA || notReadyB;
    end

    // Mul/div scoreboard state and destination register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mdState <= IDLE;
            mdRdQ   <= '0;
        end else begin
            mdState <= mdStateNext;
            mdRdQ   <= mdRdNext;
        end
    end

    // Mul/div next state; a start squashed by a redirect never occupies the unit
    always_comb begin
        mdStateNext = mdState;
        mdRdNext    = mdRdQ;
        case (mdState)
            IDLE: begin
                if (hz.mdStartE && !hz.wrongBranchE) begin
                    mdStateNext = BUSY;
                    mdRdNext    = hz.mdRdE;
                end
            end
            BUSY: begin
                if (hz.mdDone) begin
                    mdStateNext = WB;
                end
            end
            WB: begin
                if (hz.mdStartE && !hz.wrongBranchE) begin
                    mdStateNext = BUSY;
                    mdRdNext    = hz.mdRdE;
                end else begin
                    mdStateNext = IDLE;
                end
            end
            default: mdStateNext = IDLE;
        endcase
    end

    // Decode waits while it reads the pending mul/div destination
    always_comb begin
        mdBusyInt = (mdState == BUSY);
        mdStall   = mdBusyInt && (mdRdQ != '0)
                    && ((hz.r1AddrD == mdRdQ) || (hz.r2AddrD == mdRdQ));
        stallAny  = useStall || mdStall;
    end

    assign hz.fwdAE  = fwdA;
    assign hz.fwdBE  = fwdB;
    assign hz.stallF = stallAny;
    assign hz.stallD = stallAny;
    assign hz.flushE = stallAny || hz.wrongBranchE;
    assign hz.flushD = hz.wrongBranchE;
    assign hz.flushF = {FETCH_STG{hz.wrongBranchE}};
    assign hz.mdBusy = mdBusyInt;

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCntQ;
    logic [31:0] flushCntQ;

    // Saturating stall / flush cycle counters
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (stallAny && (stallCntQ != 32'hFFFF_FFFF)) begin
                stallCntQ <= stallCntQ + 32'd1;
            end
            if ((stallAny || hz.wrongBranchE) && (flushCntQ != 32'hFFFF_FFFF)) begin
                flushCntQ <= flushCntQ + 32'd1;
            end
        end
    end

    assign hz.stallCnt = stallCntQ;
    assign hz.flushCnt = flushCntQ;
`endif

endmodule

// File: tb/tb_hazard_ctrl_n.sv
// tb/tb_hazard_ctrl_n.sv - scoreboard bench for hazard_ctrl_n (HAZARD_PERF_EN adds counter checks)
module tb_hazard_ctrl_n;

    logic clk;
    logic rstN;

    hazard_ctrl_n_if #(.N_FWD(3), .FETCH_STG(2), .REG_AW(5)) hz ();

    hazard_ctrl_n #(.N_FWD(3), .FETCH_STG(2), .REG_AW(5)) dut (
        .clk  (clk),
        .rstN (rstN),
        .hz   (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {fwdAE, fwdBE, stallF, stallD, flushD, flushE, flushF, mdBusy}
    logic [10:0] obs;
    assign obs = {hz.fwdAE, hz.fwdBE, hz.stallF, hz.stallD, hz.flushD,
                  hz.flushE, hz.flushF, hz.mdBusy};

    logic [10:0] expQ[$];
    logic [10:0] want;
    int nChecks = 0;
    int nFails  = 0;

    function automatic logic [10:0] expv(input int fa, input int fb, input bit st,
                                         input bit fe, input bit br, input bit busy);
        logic [1:0] a2;
        logic [1:0] b2;
        a2 = fa[1:0];
        b2 = fb[1:0];
        return {a2, b2, st, st, br, fe, br, br, busy};
    endfunction

    task automatic idle();
        hz.r1AddrD      = '0;
        hz.r2AddrD      = '0;
        hz.r1AddrE      = '0;
        hz.r2AddrE      = '0;
        hz.rdE          = '0;
        hz.regWriteE    = 1'b0;
        hz.notReadyE    = 1'b0;
        hz.rdStg        = '0;
        hz.regWriteStg  = '0;
        hz.notReadyStg  = '0;
        hz.mdStartE     = 1'b0;
        hz.mdRdE        = '0;
        hz.mdDone       = 1'b0;
        hz.wrongBranchE = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        idle();
        #2;
        expQ.push_back(expv(0, 0, 0, 0, 0, 0));
        want = expQ.pop_front();
        nChecks++;
        if (obs !== want) begin
            nFails++;
            $display("FAIL reset_outputs: got %b want %b", obs, want);
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_forwarding();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            idle();
            hz.rdStg       = {5'd7, 5'd7, 5'd7};
            hz.regWriteStg = 3'b111;
            hz.r1AddrE     = 5'd7;
            case (k)
                0: expQ.push_back(expv(1, 0, 0, 0, 0, 0));
                1: begin
                    hz.regWriteStg = 3'b110;
                    hz.r2AddrE     = 5'd7;
                    expQ.push_back(expv(2, 2, 0, 0, 0, 0));
                end
                2: begin
                    hz.regWriteStg = 3'b100;
                    expQ.push_back(expv(3, 0, 0, 0, 0, 0));
                end
                3: begin
                    hz.rdStg   = '0;
                    hz.r1AddrE = 5'd0;
                    hz.r2AddrE = 5'd0;
                    expQ.push_back(expv(0, 0, 0, 0, 0, 0));
                end
                4: begin
                    hz.rdStg   = {5'd7, 5'd7, 5'd3};
                    hz.r2AddrE = 5'd3;
                    expQ.push_back(expv(2, 1, 0, 0, 0, 0));
                end
                5: begin
                    hz.notReadyStg = 3'b001;
                    expQ.push_back(expv(1, 0, 1, 1, 0, 0));
                end
                6: begin
                    hz.notReadyStg = 3'b010;
                    expQ.push_back(expv(1, 0, 0, 0, 0, 0));
                end
                default: begin
                    hz.regWriteStg = 3'b000;
                    hz.notReadyStg = 3'b111;
                    expQ.push_back(expv(0, 0, 0, 0, 0, 0));
                end
            endcase
            @(negedge clk);
            want = expQ.pop_front();
            nChecks++;
            if (obs !== want) begin
                nFails++;
                $display("FAIL forwarding_%0d: got %b want %b", k, obs, want);
            end
        end
    endtask

    task automatic test_load_use();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            idle();
            hz.regWriteE = 1'b1;
            hz.notReadyE = 1'b1;
            hz.rdE       = 5'd5;
            hz.r2AddrD   = 5'd5;
            case (k)
                0: expQ.push_back(expv(0, 0, 1, 1, 0, 0));
                1: begin
                    hz.rdE     = 5'd0;
                    hz.r2AddrD = 5'd0;
                    expQ.push_back(expv(0, 0, 0, 0, 0, 0));
                end
                2: begin
                    hz.notReadyE = 1'b0;
                    expQ.push_back(expv(0, 0, 0, 0, 0, 0));
                end
                default: begin
                    hz.r2AddrD = 5'd4;
                    hz.r1AddrD = 5'd5;
                    expQ.push_back(expv(0, 0, 1, 1, 0, 0));
                end
            endcase
            @(negedge clk);
            want = expQ.pop_front();
            nChecks++;
            if (obs !== want) begin
                nFails++;
                $display("FAIL load_use_%0d: got %b want %b", k, obs, want);
            end
        end
    endtask

    task automatic test_muldiv();
        bit busy;
        // First op: start at cycle 0, done during cycle 5, WB in cycle 6
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            idle();
            hz.mdStartE = (k == 0);
            hz.mdRdE    = 5'd9;
            hz.mdDone   = (k == 5);
            hz.r1AddrD  = (k <= 5) ? 5'd9 : 5'd0;
            busy = (k >= 1) && (k <= 5);
            expQ.push_back(expv(0, 0, busy, busy, 0, busy));
            @(negedge clk);
            want = expQ.pop_front();
            nChecks++;
            if (obs !== want) begin
                nFails++;
                $display("FAIL muldiv_seq_%0d: got %b want %b", k, obs, want);
            end
        end
        // Back-to-back: restart while in WB with a new destination
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            idle();
            hz.mdStartE = (k == 0) || (k == 3);
            hz.mdRdE    = (k == 0) ? 5'd9 : 5'd3;
            hz.mdDone   = (k == 2);
            hz.r1AddrD  = 5'd9;
            hz.r2AddrD  = (k >= 4) ? 5'd3 : 5'd0;
            case (k)
                0: expQ.push_back(expv(0, 0, 0, 0, 0, 0));
                1: expQ.push_back(expv(0, 0, 1, 1, 0, 1));
                2: expQ.push_back(expv(0, 0, 1, 1, 0, 1));
                3: expQ.push_back(expv(0, 0, 0, 0, 0, 0));
                default: expQ.push_back(expv(0, 0, 1, 1, 0, 1));
            endcase
            @(negedge clk);
            want = expQ.pop_front();
            nChecks++;
            if (obs !== want) begin
                nFails++;
                $display("FAIL muldiv_b2b_%0d: got %b want %b", k, obs, want);
            end
        end
        // Drain the second op back to IDLE
        @(posedge clk); #1;
        idle();
        hz.mdDone = 1'b1;
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_branch();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            idle();
            case (k)
                0: begin
                    hz.regWriteE    = 1'b1;
                    hz.notReadyE    = 1'b1;
                    hz.rdE          = 5'd5;
                    hz.r1AddrD      = 5'd5;
                    hz.wrongBranchE = 1'b1;
                    hz.mdStartE     = 1'b1;
                    hz.mdRdE        = 5'd9;
                    expQ.push_back(expv(0, 0, 1, 1, 1, 0));
                end
                1: begin
                    hz.r1AddrD = 5'd9;
                    expQ.push_back(expv(0, 0, 0, 0, 0, 0));
                end
                default: begin
                    hz.wrongBranchE = 1'b1;
                    expQ.push_back(expv(0, 0, 0, 1, 1, 0));
                end
            endcase
            @(negedge clk);
            want = expQ.pop_front();
            nChecks++;
            if (obs !== want) begin
                nFails++;
                $display("FAIL branch_%0d: got %b want %b", k, obs, want);
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        idle();
        hz.mdStartE = 1'b1;
        hz.mdRdE    = 5'd9;
        @(posedge clk); #1;
        idle();
        expQ.push_back(expv(0, 0, 0, 0, 0, 1));
        @(negedge clk);
        want = expQ.pop_front();
        nChecks++;
        if (obs !== want) begin
            nFails++;
            $display("FAIL async_busy: got %b want %b", obs, want);
        end
        #2;
        rstN = 1'b0;
        expQ.push_back(expv(0, 0, 0, 0, 0, 0));
        #1;
        want = expQ.pop_front();
        nChecks++;
        if (obs !== want) begin
            nFails++;
            $display("FAIL async_reset_now: got %b want %b", obs, want);
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            idle();
            hz.r1AddrD = 5'd9;
            expQ.push_back(expv(0, 0, 0, 0, 0, 0));
            @(negedge clk);
            want = expQ.pop_front();
            nChecks++;
            if (obs !== want) begin
                nFails++;
                $display("FAIL async_after_%0d: got %b want %b", k, obs, want);
            end
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        logic [63:0] cntQ[$];
        logic [63:0] cntWant;
        @(negedge clk);
        rstN = 1'b0;
        idle();
        #2;
        cntQ.push_back(64'd0);
        cntWant = cntQ.pop_front();
        nChecks++;
        if ({hz.stallCnt, hz.flushCnt} !== cntWant) begin
            nFails++;
            $display("FAIL perf_reset: got %h want %h", {hz.stallCnt, hz.flushCnt}, cntWant);
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            idle();
            if (k < 4) begin
                hz.regWriteE = 1'b1;
                hz.notReadyE = 1'b1;
                hz.rdE       = 5'd5;
                hz.r2AddrD   = 5'd5;
            end else if (k == 4) begin
                hz.wrongBranchE = 1'b1;
            end
        end
        cntQ.push_back({32'd4, 32'd5});
        @(negedge clk);
        cntWant = cntQ.pop_front();
        nChecks++;
        if ({hz.stallCnt, hz.flushCnt} !== cntWant) begin
            nFails++;
            $display("FAIL perf_counts: got %h want %h", {hz.stallCnt, hz.flushCnt}, cntWant);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_muldiv();
        test_branch();
        test_async_reset();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
